// File: rtl/ex_stage.sv
// Execute stage: operand select, priority-encoded ALU, and an iterative
// 1-bit-per-cycle shifter that stalls upstream while it runs.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        alu_rs2_reg,
  input  logic [31:0] imm,
  input  logic        add_en,
  input  logic        sub_en,
  input  logic        xor_en,
  input  logic        or_en,
  input  logic        and_en,
  input  logic        sll_en,
  input  logic        srl_en,
  input  logic        sra_en,
  input  logic        rs1_alu_loopback,
  input  logic        rs2_alu_loopback,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] result_out,
  output logic        wb_en_out,
  output logic        stall
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  state_t      state_r;
  logic [31:0] shreg_r;
  logic [4:0]  cnt_r;
  logic [1:0]  sh_op_r;
  logic [4:0]  rd_r;

  logic [31:0] op_a_s;
  logic [31:0] op_b_s;
  logic [4:0]  amt_s;
  logic [31:0] alu_res_s;
  logic        op_active_s;
  logic        is_shift_s;
  logic [1:0]  sh_op_s;

  // One shifter step for the latched shift kind.
  function automatic logic [31:0] shift_step(input logic [31:0] v, input logic [1:0] op);
    case (op)
      SH_SLL:  shift_step = {v[30:0], 1'b0};
      SH_SRL:  shift_step = {1'b0, v[31:1]};
      SH_SRA:  shift_step = {v[31], v[31:1]};
      default: shift_step = v;
    endcase
  endfunction

  // Operand selection and priority-encoded single-cycle ALU.
  always_comb begin
    op_a_s      = rs1_alu_loopback ? result_out : rs1;
    if (alu_rs2_reg) begin
      op_b_s = rs2_alu_loopback ? result_out : rs2;
    end else begin
      op_b_s = imm;
    end
    amt_s       = op_b_s[4:0];
    alu_res_s   = 32'd0;
    op_active_s = 1'b1;
    is_shift_s  = 1'b0;
    sh_op_s     = SH_SLL;
    if (add_en) begin
      alu_res_s = op_a_s + op_b_s;
    end else if (sub_en) begin
      alu_res_s = op_a_s - op_b_s;
    end else if (xor_en) begin
      alu_res_s = op_a_s ^ op_b_s;
    end else if (or_en) begin
      alu_res_s = op_a_s | op_b_s;
    end else if (and_en) begin
      alu_res_s = op_a_s & op_b_s;
    end else if (sll_en) begin
      is_shift_s = 1'b1;
      sh_op_s    = SH_SLL;
      alu_res_s  = op_a_s;
    end else if (srl_en) begin
      is_shift_s = 1'b1;
      sh_op_s    = SH_SRL;
      alu_res_s  = op_a_s;
    end else if (sra_en) begin
      is_shift_s = 1'b1;
      sh_op_s    = SH_SRA;
      alu_res_s  = op_a_s;
    end else begin
      op_active_s = 1'b0;
    end
  end

  // Stall while a shift is being issued or has more than one step left.
  always_comb begin
    if (!rst) begin
      stall = 1'b0;
    end else if (state_r == IDLE) begin
      stall = is_shift_s && (amt_s != 5'd0);
    end else begin
      stall = (cnt_r > 5'd1);
    end
  end

  // Stage FSM and EX/WB output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      shreg_r     <= 32'd0;
      cnt_r       <= 5'd0;
      sh_op_r     <= SH_SLL;
      rd_r        <= 5'd0;
      result_out  <= 32'd0;
      rd_addr_out <= 5'd0;
      wb_en_out   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_shift_s && (amt_s != 5'd0)) begin
            shreg_r   <= op_a_s;
            cnt_r     <= amt_s;
            sh_op_r   <= sh_op_s;
            rd_r      <= rd_addr;
            wb_en_out <= 1'b0;
            state_r   <= SHIFT;
          end else begin
            result_out  <= alu_res_s;
            rd_addr_out <= rd_addr;
            wb_en_out   <= op_active_s && (rd_addr != 5'd0);
          end
        end
        SHIFT: begin
          shreg_r <= shift_step(shreg_r, sh_op_r);
          cnt_r   <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            result_out  <= shift_step(shreg_r, sh_op_r);
            rd_addr_out <= rd_r;
            wb_en_out   <= (rd_r != 5'd0);
            state_r     <= IDLE;
          end else begin
            wb_en_out <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          wb_en_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr;
  logic [31:0] rs1, rs2, imm;
  logic        alu_rs2_reg;
  logic        add_en, sub_en, xor_en, or_en, and_en, sll_en, srl_en, sra_en;
  logic        rs1_alu_loopback, rs2_alu_loopback;
  logic [4:0]  rd_addr_out;
  logic [31:0] result_out;
  logic        wb_en_out;
  logic        stall;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res;

  ex_stage dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rs1(rs1), .rs2(rs2),
    .alu_rs2_reg(alu_rs2_reg), .imm(imm),
    .add_en(add_en), .sub_en(sub_en), .xor_en(xor_en), .or_en(or_en),
    .and_en(and_en), .sll_en(sll_en), .srl_en(srl_en), .sra_en(sra_en),
    .rs1_alu_loopback(rs1_alu_loopback), .rs2_alu_loopback(rs2_alu_loopback),
    .rd_addr_out(rd_addr_out), .result_out(result_out),
    .wb_en_out(wb_en_out), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // en bits: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra
  task automatic drive(input logic [7:0] en, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] rd, input logic b_reg,
                       input logic l1, input logic l2);
    {sra_en, srl_en, sll_en, and_en, or_en, xor_en, sub_en, add_en} = en;
    rs1 = a; rs2 = b; imm = im; rd_addr = rd;
    alu_rs2_reg = b_reg; rs1_alu_loopback = l1; rs2_alu_loopback = l2;
  endtask

  task automatic run_shift(input logic [7:0] en, input logic [31:0] a, input logic [4:0] amt,
                           input logic [4:0] rd, input logic l1, input logic [31:0] exp,
                           input string nm);
    drive(en, a, 32'd0, {27'd0, amt}, rd, 1'b0, l1, 1'b0);
    #1;
    for (int c = 0; c < int'(amt); c++) begin
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL %s_stall cycle=%0d got=%b exp=1", nm, c, stall);
      end
      if (c > 0) begin
        checks++;
        if (wb_en_out !== 1'b0 || result_out !== last_res) begin
          failures++;
          $display("FAIL %s_hold cycle=%0d wb=%b res=%h exp wb=0 res=%h", nm, c, wb_en_out, result_out, last_res);
        end
        rs1 = ~a;
      end
      tick;
    end
    checks++;
    if (stall !== 1'b0 || wb_en_out !== 1'b0 || result_out !== last_res) begin
      failures++;
      $display("FAIL %s_last stall=%b wb=%b res=%h exp stall=0 wb=0 res=%h", nm, stall, wb_en_out, result_out, last_res);
    end
    tick;
    checks++;
    if (result_out !== exp || rd_addr_out !== rd || wb_en_out !== (rd != 5'd0)) begin
      failures++;
      $display("FAIL %s_result res=%h rd=%0d wb=%b exp res=%h rd=%0d", nm, result_out, rd_addr_out, wb_en_out, exp, rd);
    end
    last_res = exp;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(8'h80, 32'h80000010, 32'd0, 32'd4, 5'd9, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    tick;
    checks++;
    if (result_out !== 32'd0 || rd_addr_out !== 5'd0 || wb_en_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs res=%h rd=%0d wb=%b exp all 0", result_out, rd_addr_out, wb_en_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_add;
    drive(8'h01, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL add_stall got=%b exp=0", stall); end
    tick;
    checks++;
    if (result_out !== 32'd1 || rd_addr_out !== 5'd5 || wb_en_out !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap res=%h rd=%0d wb=%b exp res=1 rd=5 wb=1", result_out, rd_addr_out, wb_en_out);
    end
  endtask

  task automatic test_sub_loopback;
    drive(8'h02, 32'd10, 32'd0, 32'd3, 5'd6, 1'b0, 1'b0, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'd7 || wb_en_out !== 1'b1) begin
      failures++; $display("FAIL sub_imm res=%h wb=%b exp res=7 wb=1", result_out, wb_en_out);
    end
    drive(8'h04, 32'd0, 32'hF, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'h8 || rd_addr_out !== 5'd7) begin
      failures++; $display("FAIL xor_loopback res=%h rd=%0d exp res=8 rd=7", result_out, rd_addr_out);
    end
    drive(8'h08, 32'h1, 32'hFFFF, 32'h100, 5'd3, 1'b0, 1'b0, 1'b1);
    tick;
    checks++;
    if (result_out !== 32'h101) begin
      failures++; $display("FAIL rs2_lb_ignored res=%h exp=00000101", result_out);
    end
    drive(8'h10, 32'h1F0, 32'hFFFF, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1);
    tick;
    checks++;
    if (result_out !== 32'h100) begin
      failures++; $display("FAIL and_rs2_lb res=%h exp=00000100", result_out);
    end
  endtask

  task automatic test_priority;
    drive(8'h03, 32'd5, 32'd3, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'd8) begin failures++; $display("FAIL prio_add_sub res=%h exp=8", result_out); end
    drive(8'h1C, 32'hF0, 32'h3C, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'hCC) begin failures++; $display("FAIL prio_xor res=%h exp=cc", result_out); end
  endtask

  task automatic test_x0_bubble;
    drive(8'h01, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'd0 || wb_en_out !== 1'b0) begin
      failures++; $display("FAIL x0_zero res=%h wb=%b exp res=0 wb=0", result_out, wb_en_out);
    end
    drive(8'h01, 32'd1, 32'd1, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'd2 || wb_en_out !== 1'b0) begin
      failures++; $display("FAIL x0_nonzero res=%h wb=%b exp res=2 wb=0", result_out, wb_en_out);
    end
    drive(8'h00, 32'd5, 32'd6, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'd0 || wb_en_out !== 1'b0) begin
      failures++; $display("FAIL bubble res=%h wb=%b exp res=0 wb=0", result_out, wb_en_out);
    end
    last_res = 32'd0;
  endtask

  task automatic test_sra;
    run_shift(8'h80, 32'h80000010, 5'd4, 5'd9, 1'b0, 32'hF8000001, "sra4");
    drive(8'h01, 32'd0, 32'd0, 32'd1, 5'd10, 1'b0, 1'b1, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'hF8000002 || rd_addr_out !== 5'd10 || wb_en_out !== 1'b1) begin
      failures++; $display("FAIL sra_then_lb res=%h rd=%0d exp res=f8000002 rd=10", result_out, rd_addr_out);
    end
    last_res = 32'hF8000002;
  endtask

  task automatic test_shift_bounds;
    drive(8'h20, 32'h1234, 32'd0, 32'd0, 5'd8, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL sll0_stall got=%b exp=0", stall); end
    tick;
    checks++;
    if (result_out !== 32'h1234 || wb_en_out !== 1'b1 || rd_addr_out !== 5'd8) begin
      failures++; $display("FAIL sll0_result res=%h wb=%b exp res=1234 wb=1", result_out, wb_en_out);
    end
    last_res = 32'h1234;
    run_shift(8'h40, 32'h80000000, 5'd31, 5'd12, 1'b0, 32'd1, "srl31");
  endtask

  task automatic test_back_to_back;
    run_shift(8'h20, 32'd3, 5'd2, 5'd11, 1'b0, 32'hC, "b2b_sll");
    run_shift(8'h40, 32'd0, 5'd1, 5'd13, 1'b1, 32'h6, "b2b_srl");
  endtask

  task automatic test_reset_mid_shift;
    drive(8'h20, 32'h5, 32'd0, 32'd10, 5'd4, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL rms_issue_stall got=%b exp=1", stall); end
    tick; tick; tick;
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL rms_stall_in_rst got=%b exp=0", stall); end
    tick;
    checks++;
    if (result_out !== 32'd0 || rd_addr_out !== 5'd0 || wb_en_out !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rms_cleared res=%h rd=%0d wb=%b stall=%b exp all 0", result_out, rd_addr_out, wb_en_out, stall);
    end
    rst = 1'b1;
    drive(8'h01, 32'd3, 32'd4, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL rms_add_stall got=%b exp=0", stall); end
    tick;
    checks++;
    if (result_out !== 32'd7 || rd_addr_out !== 5'd2 || wb_en_out !== 1'b1) begin
      failures++; $display("FAIL rms_add res=%h rd=%0d wb=%b exp res=7 rd=2 wb=1", result_out, rd_addr_out, wb_en_out);
    end
    drive(8'h00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick;
    checks++;
    if (result_out !== 32'd0 || wb_en_out !== 1'b0) begin
      failures++; $display("FAIL rms_no_late_result res=%h wb=%b exp res=0 wb=0", result_out, wb_en_out);
    end
  endtask

  initial begin
    last_res = 32'd0;
    test_reset;
    test_add;
    test_sub_loopback;
    test_priority;
    test_x0_bubble;
    test_sra;
    test_shift_bounds;
    test_back_to_back;
    test_reset_mid_shift;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined RISC-V core, sitting directly downstream of the ID/EX pipeline register. It selects operands (register, immediate or ALU loopback) and performs the one-hot ALU operation. Single-cycle operations are registered into the EX/WB output. Shifts run on an iterative 1-bit-per-cycle shifter, and the stage stalls upstream while a shift is in progress.

## Interface
- No parameters; XLEN fixed at 32, register address 5 bits.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- rd_addr  in  5  destination register from ID/EX
- rs1, rs2  in  32  register operands from ID/EX
- alu_rs2_reg  in  1  selects the B operand: 1 = rs2 path, 0 = imm
- imm  in  32  sign-extended immediate
- add_en, sub_en, xor_en, or_en, and_en, sll_en, srl_en, sra_en  in  1 each  one-hot operation enables
- rs1_alu_loopback, rs2_alu_loopback  in  1 each  substitute result_out for rs1 / rs2
- rd_addr_out  out  5  registered destination to EX/WB consumer
- result_out  out  32  registered ALU result
- wb_en_out  out  1  registered writeback enable
- stall  out  1  combinational; 1 = ID/EX and upstream must hold their contents

## Operation
- Operand A = rs1_alu_loopback ? result_out : rs1.
- Operand B = alu_rs2_reg ? (rs2_alu_loopback ? result_out : rs2) : imm.
- rs2_alu_loopback is ignored when alu_rs2_reg=0.
- Enable priority if more than one is set: add > sub > xor > or > and > sll > srl > sra. If no enable is set, the op is a bubble: result 0, wb_en 0.
- add/sub wrap modulo 2^32. Logic ops are bitwise.
- Shift amount = B[4:0]. sll and srl zero-fill; sra fills with A[31].
- wb_en_out = op active AND rd_addr != 0. A write to x0 is never enabled.
- FSM states: IDLE and SHIFT, with an internal 32-bit shreg, 5-bit cnt, op latch and rd latch.
- IDLE, non-shift op, or shift with amount 0:
  - stall = 0.
  - Next edge: result_out, rd_addr_out and wb_en_out are loaded. An amount-0 shift returns A.
- IDLE, shift with amount n > 0:
  - stall = 1.
  - Next edge: shreg = A, cnt = n, latch op and rd, go to SHIFT.
  - Next edge also sets wb_en_out to 0; result_out and rd_addr_out are held.
- SHIFT, each cycle: shreg shifts 1 bit per the latched op, cnt decrements.
  - cnt > 1: stall = 1; outputs hold with wb_en_out = 0.
  - cnt == 1: stall = 0. Next edge loads the final shifted value into result_out, sets rd_addr_out from the latch and wb_en_out per rule, and returns to IDLE.
- ID/EX inputs are ignored while in SHIFT, because upstream holds them.
- While stalled, result_out keeps its last value, so loopback remains coherent. The instruction after a shift sees the shift result through loopback.

## Timing
- Reset (rst=0 at an edge): result_out=0, rd_addr_out=0, wb_en_out=0, state=IDLE, cnt=0, shreg=0. stall=0 while in reset.
- Reset mid-shift aborts the shift; no result is produced and the state returns to IDLE.
- Reset overrides all other activity in the same cycle.
- Single-cycle ops: latency 1 cycle, throughput 1 op per cycle.
- Shift by n > 0:
  - stall is high for n consecutive cycles (the issue cycle plus n-1 SHIFT cycles).
  - The result is registered at the end of cycle n (latency n+1).
  - wb_en_out is 0 for the n cycles preceding the result.
- Back-to-back shifts: the second shift issues in the cycle after the first completes, with no extra idle cycle.
- stall depends only on state, cnt and the current-cycle enables/operands. It has no dependency on downstream signals.

## Test plan
- Reset then ALU ops:
  - rst=0 one cycle: all outputs 0.
  - add rs1=0xFFFFFFFF, rs2=2, rd=5 → next cycle result_out=1, rd_addr_out=5, wb_en_out=1.
- Sub with immediate and loopback:
  - sub with alu_rs2_reg=0, imm=3, rs1=10 → result 7.
  - Next cycle: xor with rs1_alu_loopback=1, rs2=0xF → result 0x8.
- x0 and bubble:
  - add rd=0, rs1=rs2=0 → wb_en_out=0, result 0.
  - All enables 0 → result 0, wb_en_out=0.
- sra by 4 of 0x80000010:
  - stall high exactly 4 cycles, wb_en_out=0 during them.
  - Result 0xF8000001 appears 5 cycles after issue; the following add with loopback sees 0xF8000001.
- Shift amounts 0 and 31:
  - sll by 0 of 0x1234 → 1-cycle result 0x1234, no stall.
  - srl by 31 of 0x80000000 → result 1 after 32 cycles.
- Reset mid-shift:
  - sll by 10, rst=0 at cycle 3 → outputs 0, stall 0, no result written.
  - Next add executes normally.
